// File: rtl/apb_req_arbiter.sv
// Two-requester round-robin APB master: grants one requester at a time, runs
// the SETUP/ACCESS handshake and aborts accesses whose pready never arrives.
module apb_req_arbiter #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              pclk,
  input  logic              preset_n,
  input  logic              req0,
  input  logic              wr0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic              wr1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              done0,
  output logic              done1,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic              pready,
  input  logic [DATA_W-1:0] prdata
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  state_t            state_reg, state_next;
  logic              ptr_reg, ptr_next;
  logic              grant_reg, grant_next;
  logic [7:0]        cnt_reg, cnt_next;
  logic [1:0]        done_reg, done_next;
  logic              err_reg, err_next;
  logic [DATA_W-1:0] rdata_reg, rdata_next;
  logic              psel_reg, psel_next;
  logic              penable_reg, penable_next;
  logic              pwrite_reg, pwrite_next;
  logic [ADDR_W-1:0] paddr_reg, paddr_next;
  logic [DATA_W-1:0] pwdata_reg, pwdata_next;
  logic              win;

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_reg   <= IDLE;
      ptr_reg     <= 1'b0;
      grant_reg   <= 1'b0;
      cnt_reg     <= '0;
      done_reg    <= '0;
      err_reg     <= 1'b0;
      rdata_reg   <= '0;
      psel_reg    <= 1'b0;
      penable_reg <= 1'b0;
      pwrite_reg  <= 1'b0;
      paddr_reg   <= '0;
      pwdata_reg  <= '0;
    end else begin
      state_reg   <= state_next;
      ptr_reg     <= ptr_next;
      grant_reg   <= grant_next;
      cnt_reg     <= cnt_next;
      done_reg    <= done_next;
      err_reg     <= err_next;
      rdata_reg   <= rdata_next;
      psel_reg    <= psel_next;
      penable_reg <= penable_next;
      pwrite_reg  <= pwrite_next;
      paddr_reg   <= paddr_next;
      pwdata_reg  <= pwdata_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    ptr_next     = ptr_reg;
    grant_next   = grant_reg;
    cnt_next     = cnt_reg;
    done_next    = '0;
    err_next     = err_reg;
    rdata_next   = rdata_reg;
    psel_next    = psel_reg;
    penable_next = penable_reg;
    pwrite_next  = pwrite_reg;
    paddr_next   = paddr_reg;
    pwdata_next  = pwdata_reg;
    win          = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req0 || req1) begin
          // The pointer only matters on a collision; it always moves past the winner.
          win          = (req0 && req1) ? ptr_reg : req1;
          grant_next   = win;
          ptr_next     = ~win;
          pwrite_next  = win ? wr1 : wr0;
          paddr_next   = win ? addr1 : addr0;
          pwdata_next  = win ? wdata1 : wdata0;
          psel_next    = 1'b1;
          penable_next = 1'b0;
          state_next   = SETUP;
        end
      end
      SETUP: begin
        penable_next = 1'b1;
        state_next   = ACCESS;
      end
      ACCESS: begin
        if (pready) begin
          if (!pwrite_reg) rdata_next = prdata;
          err_next             = 1'b0;
          psel_next            = 1'b0;
          penable_next         = 1'b0;
          done_next[grant_reg] = 1'b1;
          cnt_next             = '0;
          state_next           = DONE;
        end else if (cnt_reg == 8'(TIMEOUT - 1)) begin
          // This wait cycle is the TIMEOUT-th one without pready.
          err_next             = 1'b1;
          rdata_next           = '0;
          psel_next            = 1'b0;
          penable_next         = 1'b0;
          done_next[grant_reg] = 1'b1;
          cnt_next             = '0;
          state_next           = DONE;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign done0   = done_reg[0];
  assign done1   = done_reg[1];
  assign err     = err_reg;
  assign rdata   = rdata_reg;
  assign psel    = psel_reg;
  assign penable = penable_reg;
  assign pwrite  = pwrite_reg;
  assign paddr   = paddr_reg;
  assign pwdata  = pwdata_reg;

endmodule
